fft_pts_serializer: RTL and testbench
=====================================

// Module: fft_pts_serializer
// PURPOSE
//  Multi-channel parallel-to-serial output stage for FFT result frames.
//  - On out_strobe, captures NUM_CH words of WIDTH bits in one cycle.
//  - Emits them on a single serial_out line: channel 0 first, then channel 1, and so on.
//  - Advances one bit per shift_enable cycle.
//  - Adds frame/word framing, a busy/done handshake and overrun detection for downstream links.
// PARAMETERS
//  WIDTH      32  bits per channel word (>=2)
//  NUM_CH     16  channels per frame (>=2, power of 2 not required)
//  MSB_FIRST  1   1: each word goes out MSB first; 0: LSB first
// PORTS
//  clk           in   1             system clock, rising edge
//  n_rst         in   1             asynchronous reset, active-low
//  out_strobe    in   1             load frame from parallel_in; priority over shift_enable
//  shift_enable  in   1             advance serial_out to next bit (ignored when idle)
//  parallel_in   in   NUM_CH*WIDTH  channel k at [k*WIDTH +: WIDTH]
//  clr_overrun   in   1             clears sticky overrun
//  serial_out    out  1             current bit; 0 when idle
//  busy          out  1             frame loaded, bits remaining
//  ch_idx        out  CH_W          channel currently on serial_out; CH_W=$clog2(NUM_CH)
//  word_start    out  1             high while first bit of a word is presented
//  frame_done    out  1             one-cycle pulse after last bit of frame shifted
//  overrun       out  1             sticky: out_strobe arrived while busy
// BEHAVIOUR
//  - Reset (async, n_rst=0): state IDLE. Buffer, bit_cnt and ch_idx cleared.
//    serial_out, busy, word_start, frame_done and overrun are all 0.
//  - States: IDLE, SHIFT. All outputs registered; no combinational input->output path.
//  - IDLE & out_strobe at edge t:
//    - buffer <= parallel_in; bit_cnt=0; ch_idx=0.
//    - From t+1: state SHIFT, busy=1, word_start=1.
//    - serial_out shows bit WIDTH-1 (MSB_FIRST) or bit 0 of ch0.
//  - SHIFT & shift_enable & !out_strobe:
//    - Next edge presents the next bit.
//    - bit_cnt wraps WIDTH-1 -> 0, and ch_idx increments on the wrap.
//    - word_start=1 exactly when bit_cnt==0.
//  - Last bit (ch_idx==NUM_CH-1, bit_cnt==WIDTH-1) & shift_enable:
//    - Next cycle: IDLE, busy=0, serial_out=0, ch_idx=0, word_start=0, frame_done=1 for one cycle.
//  - SHIFT & out_strobe (any shift_enable):
//    - Overrun is set.
//    - The frame reloads from parallel_in and restarts at ch0 bit 0 (load wins).
//    - frame_done is not pulsed.
//  - out_strobe on the same edge frame_done would assert:
//    - Counts as a normal load, not an overrun: frame_done=1 and busy=1 simultaneously.
//  - shift_enable held low in SHIFT: all outputs hold indefinitely.
//  - clr_overrun & a new overrun on the same edge: overrun stays 1 (set wins).
//  - Total shift cycles per frame: exactly NUM_CH*WIDTH. A frame is never truncated.
//  - Bit selection: a shift-register is preferred over a WIDTH-bit mux.
//    - Per-channel registers shift toward the output end.
//    - The channel select comes from ch_idx.
// STRUCTURE
//  - fft_pkg: pts_state_e {IDLE,SHIFT} and default WIDTH/NUM_CH constants shared with the FFT core.
//  - Sub-module pts_word_sr (WIDTH, MSB_FIRST), instantiated NUM_CH times via generate:
//    - load/shift inputs; head_bit output.
//    - Shifts only when its channel is selected.
//  - Top holds the FSM, bit_cnt, ch_idx, output registers and overrun flag.
// TESTING (run with WIDTH=4, NUM_CH=2 and default 32/16)
//  1. Reset mid-frame:
//     - Set n_rst=0 async during SHIFT.
//     - All outputs go 0 immediately, without waiting for clk.
//     - After release, idle holds with serial_out=0.
//  2. Basic frame, MSB_FIRST=1, ch0=4'hA, ch1=4'h3, shift_enable constant 1:
//     - serial_out = 1,0,1,0,0,0,1,1.
//     - word_start on bits 0 and 4.
//     - frame_done pulse 1 cycle after 8th bit; busy high for 8 cycles.
//  3. Same data with MSB_FIRST=0 and shift_enable toggling 1,0:
//     - Sequence 0,1,0,1,1,1,0,0.
//     - Each bit holds 2 cycles; busy lasts 16 cycles.
//  4. out_strobe during bit 5 with new ch0=4'hF, ch1=4'h0:
//     - overrun=1; restarts at ch0 bit 0 with serial 1,1,1,1,0,0,0,0.
//     - No frame_done for the aborted frame.
//     - clr_overrun then clears the flag.
//  5. out_strobe coincident with last-bit shift:
//     - frame_done=1 and busy=1 in the same cycle; overrun stays 0.
//  6. Defaults, random 512-bit frame, random shift_enable:
//     - Scoreboard reconstructs all 16 words exactly; 512 shifts per frame.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT output-stage types and default frame geometry.
package fft_pkg;
  localparam int FFT_WIDTH  = 32;
  localparam int FFT_NUM_CH = 16;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} pts_state_e;
endpackage

// File: rtl/pts_word_sr.sv
// One channel word shift register; shifts toward the output end only when selected.
module pts_word_sr #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_word,
  output logic             head_bit
);
  localparam int HEAD = MSB_FIRST ? WIDTH - 1 : 0;

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load)       sr_d = load_word;
    else if (shift) sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  // Head of the value about to be stored, so the top can register serial_out.
  assign head_bit = sr_d[HEAD];
endmodule

// File: rtl/fft_pts_serializer.sv
// Multi-channel parallel-to-serial stage for FFT frames with word/frame framing and overrun flag.
module fft_pts_serializer
  import fft_pkg::*;
#(
  parameter int WIDTH     = FFT_WIDTH,
  parameter int NUM_CH    = FFT_NUM_CH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    out_strobe,
  input  logic                    shift_enable,
  input  logic [NUM_CH*WIDTH-1:0] parallel_in,
  input  logic                    clr_overrun,
  output logic                    serial_out,
  output logic                    busy,
  output logic [CH_W-1:0]         ch_idx,
  output logic                    word_start,
  output logic                    frame_done,
  output logic                    overrun
);
  localparam int BC_W = $clog2(WIDTH);

  pts_state_e       state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
  logic             serial_out_q, serial_out_d;
  logic             busy_q, busy_d;
  logic             word_start_q, word_start_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic             adv, last;
  logic [NUM_CH-1:0] shift_lane, head_nxt;

  assign adv  = (state_q == SHIFT) && shift_enable && !out_strobe;
  assign last = (ch_idx_q == CH_W'(NUM_CH - 1)) && (bit_cnt_q == BC_W'(WIDTH - 1));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign shift_lane[k] = adv && (ch_idx_q == CH_W'(k));
    pts_word_sr #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
      .clk       (clk),
      .n_rst     (n_rst),
      .load      (out_strobe),
      .shift     (shift_lane[k]),
      .load_word (parallel_in[k*WIDTH +: WIDTH]),
      .head_bit  (head_nxt[k])
    );
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ch_idx_d     = ch_idx_q;
    busy_d       = busy_q;
    word_start_d = word_start_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q & ~clr_overrun;
    if (out_strobe) begin
      state_d      = SHIFT;
      bit_cnt_d    = '0;
      ch_idx_d     = '0;
      busy_d       = 1'b1;
      word_start_d = 1'b1;
      // A load landing on the final shift completes that frame rather than aborting it.
      frame_done_d = (state_q == SHIFT) && shift_enable && last;
      if ((state_q == SHIFT) && !frame_done_d) overrun_d = 1'b1;
    end else if (adv) begin
      if (last) begin
        state_d      = IDLE;
        bit_cnt_d    = '0;
        ch_idx_d     = '0;
        busy_d       = 1'b0;
        word_start_d = 1'b0;
        frame_done_d = 1'b1;
      end else if (bit_cnt_q == BC_W'(WIDTH - 1)) begin
        bit_cnt_d    = '0;
        ch_idx_d     = ch_idx_q + CH_W'(1);
        word_start_d = 1'b1;
      end else begin
        bit_cnt_d    = bit_cnt_q + BC_W'(1);
        word_start_d = 1'b0;
      end
    end
    serial_out_d = (state_d == SHIFT) ? head_nxt[ch_idx_d] : 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ch_idx_q     <= '0;
      serial_out_q <= 1'b0;
      busy_q       <= 1'b0;
      word_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ch_idx_q     <= ch_idx_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      word_start_q <= word_start_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign ch_idx     = ch_idx_q;
  assign word_start = word_start_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_fft_pts_serializer.sv
// Bench for fft_pts_serializer: two 4x2 instances (MSB/LSB first) and one default 32x16 instance.
module tb_fft_pts_serializer;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;
  logic strobe = 1'b0, shift_en = 1'b0, clr = 1'b0;
  logic [511:0] pin = '0;

  logic so_a, bz_a, ws_a, fd_a, ov_a; logic [0:0] ch_a;
  logic so_b, bz_b, ws_b, fd_b, ov_b; logic [0:0] ch_b;
  logic so_c, bz_c, ws_c, fd_c, ov_c; logic [3:0] ch_c;

  fft_pts_serializer #(.WIDTH(4), .NUM_CH(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .n_rst(n_rst), .out_strobe(strobe && sel == 0), .shift_enable(shift_en && sel == 0),
    .parallel_in(pin[7:0]), .clr_overrun(clr && sel == 0), .serial_out(so_a), .busy(bz_a),
    .ch_idx(ch_a), .word_start(ws_a), .frame_done(fd_a), .overrun(ov_a));
  fft_pts_serializer #(.WIDTH(4), .NUM_CH(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .n_rst(n_rst), .out_strobe(strobe && sel == 1), .shift_enable(shift_en && sel == 1),
    .parallel_in(pin[7:0]), .clr_overrun(clr && sel == 1), .serial_out(so_b), .busy(bz_b),
    .ch_idx(ch_b), .word_start(ws_b), .frame_done(fd_b), .overrun(ov_b));
  fft_pts_serializer u_c (
    .clk(clk), .n_rst(n_rst), .out_strobe(strobe && sel == 2), .shift_enable(shift_en && sel == 2),
    .parallel_in(pin), .clr_overrun(clr && sel == 2), .serial_out(so_c), .busy(bz_c),
    .ch_idx(ch_c), .word_start(ws_c), .frame_done(fd_c), .overrun(ov_c));

  logic o_so, o_bz, o_ws, o_fd, o_ov; int o_ch;
  always_comb begin
    o_so = so_a; o_bz = bz_a; o_ws = ws_a; o_fd = fd_a; o_ov = ov_a; o_ch = int'(ch_a);
    if (sel == 1) begin o_so = so_b; o_bz = bz_b; o_ws = ws_b; o_fd = fd_b; o_ov = ov_b; o_ch = int'(ch_b); end
    if (sel == 2) begin o_so = so_c; o_bz = bz_c; o_ws = ws_c; o_fd = fd_c; o_ov = ov_c; o_ch = int'(ch_c); end
  end

  int checks = 0, failures = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".serial"}, 32'(o_so), 0);
    chk({tag, ".busy"},   32'(o_bz), 0);
    chk({tag, ".ch"},     32'(o_ch), 0);
    chk({tag, ".ws"},     32'(o_ws), 0);
    chk({tag, ".fd"},     32'(o_fd), 0);
  endtask

  // Load a frame on DUT s, push its bit stream, then consume it one shift at a time.
  // mode: 0 shift every cycle, 1 toggle starting low, 2 random. stop_at>=0 returns with
  // that bit position on serial_out, shift_enable already driven high for the next edge.
  task automatic play(input int s, input logic [511:0] data, input int mode,
                      input int stop_at, input bit exp_ov, input bit coincident);
    int w, n, msb, pos, cyc, sh;
    logic [511:0] rec;
    logic se;
    w   = (s == 2) ? 32 : 4;
    n   = (s == 2) ? 16 : 2;
    msb = (s == 1) ? 0 : 1;
    sel = s;
    exp_q.delete();
    for (int k = 0; k < n; k++)
      for (int b = 0; b < w; b++)
        exp_q.push_back(data[k*w + (msb != 0 ? w-1-b : b)]);
    strobe = 1'b1; pin = data; shift_en = coincident ? 1'b1 : (mode == 0);
    @(posedge clk); @(negedge clk);
    strobe = 1'b0;
    chk("load.overrun", 32'(o_ov), 32'(exp_ov));
    chk("load.frame_done", 32'(o_fd), 32'(coincident));
    pos = 0; cyc = 0; rec = '0;
    while (pos < n*w && cyc < 4*n*w + 20) begin
      if (pos == stop_at) begin shift_en = 1'b1; return; end
      chk("shift.busy",   32'(o_bz), 1);
      chk("shift.serial", 32'(o_so), 32'(exp_q[0]));
      chk("shift.ws",     32'(o_ws), 32'(pos % w == 0));
      chk("shift.ch",     32'(o_ch), 32'(pos / w));
      if (cyc > 0) chk("shift.fd", 32'(o_fd), 0);
      rec[(pos/w)*w + (msb != 0 ? w-1-(pos%w) : pos%w)] = o_so;
      se = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(cyc % 2) : logic'($urandom_range(0, 1));
      shift_en = se;
      @(posedge clk); @(negedge clk);
      if (se) begin void'(exp_q.pop_front()); pos++; end
      cyc++;
    end
    shift_en = 1'b0;
    chk("frame.shifts", 32'(pos), 32'(n*w));
    if (mode == 0) chk("frame.busy_cycles", 32'(cyc), 32'(n*w));
    if (mode == 1) chk("frame.busy_cycles", 32'(cyc), 32'(2*n*w));
    chk("end.frame_done", 32'(o_fd), 1);
    chk("end.busy", 32'(o_bz), 0);
    chk("end.serial", 32'(o_so), 0);
    chk("end.ch", 32'(o_ch), 0);
    chk("end.ws", 32'(o_ws), 0);
    for (int k = 0; k < n; k++) begin
      logic [31:0] wr, wd;
      wr = '0; wd = '0;
      for (int b = 0; b < w; b++) begin wr[b] = rec[k*w+b]; wd[b] = data[k*w+b]; end
      chk("recon.word", wr, wd);
    end
    @(posedge clk); @(negedge clk);
    chk("end.fd_pulse", 32'(o_fd), 0);
  endtask

  initial begin
    logic [511:0] rnd;
    #2;
    chk_idle("reset");
    chk("reset.ov", 32'(o_ov), 0);
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);

    // Basic MSB-first frame, then LSB-first with toggling shift_enable.
    play(0, 512'h3A, 0, -1, 1'b0, 1'b0);
    play(1, 512'h3A, 1, -1, 1'b0, 1'b0);

    // Overrun mid-frame: reload wins, no frame_done, then clear.
    play(0, 512'h3A, 0, 5, 1'b0, 1'b0);
    play(0, 512'h0F, 0, -1, 1'b1, 1'b0);
    chk("ov.sticky", 32'(o_ov), 1);
    clr = 1'b1; @(posedge clk); @(negedge clk); clr = 1'b0;
    chk("ov.cleared", 32'(o_ov), 0);

    // Clear and new overrun on the same edge: set wins.
    play(0, 512'h5C, 0, 2, 1'b0, 1'b0);
    clr = 1'b1;
    play(0, 512'hA5, 0, -1, 1'b1, 1'b0);
    clr = 1'b0;
    clr = 1'b1; @(posedge clk); @(negedge clk); clr = 1'b0;
    chk("ov.cleared2", 32'(o_ov), 0);

    // Load coincident with the final shift: completion plus new frame, no overrun.
    play(0, 512'hC6, 0, 7, 1'b0, 1'b0);
    play(0, 512'h9E, 0, -1, 1'b0, 1'b1);
    chk("coinc.ov", 32'(o_ov), 0);

    // Asynchronous reset mid-frame.
    play(0, 512'hFF, 0, 3, 1'b0, 1'b0);
    chk("prerst.busy", 32'(o_bz), 1);
    #2 n_rst = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk); n_rst = 1'b1; shift_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("post_rst");
    shift_en = 1'b0;

    // Default geometry, random data and random shift_enable.
    for (int i = 0; i < 16; i++) rnd[i*32 +: 32] = $urandom;
    play(2, rnd, 2, -1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
